// File: rtl/io_pkg.sv
// Shared definitions for the burst controller: default geometry, state
// encodings for the top and per-channel FSMs, and the AXI OKAY response code.
package io_pkg;

    localparam int ADDR_W_DEF     = 64;
    localparam int RLEN_W_DEF     = 35;
    localparam int WLEN_W_DEF     = 32;
    localparam int BEAT_BYTES_DEF = 64;
    localparam int MAX_BEATS_DEF  = 64;
    localparam int BOUNDARY_DEF   = 4096;
    localparam int MAX_OUTST_DEF  = 16;

    localparam logic [1:0] BRESP_OKAY = 2'b00;

    typedef enum logic [1:0] {
        CH_IDLE,
        CH_CALC,
        CH_REQ,
        CH_DONE
    } ch_state_e;

    typedef enum logic [1:0] {
        TOP_IDLE,
        TOP_BUSY,
        TOP_DRAIN,
        TOP_COMPLETE
    } top_state_e;

endpackage

// File: rtl/io_burst_ctrl_if.sv
// Job, burst-request and write-response signals of io_burst_ctrl.
// slave is the controller's view, master the driver/bus side.
interface io_burst_ctrl_if
    import io_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int RLEN_W = RLEN_W_DEF,
    parameter int WLEN_W = WLEN_W_DEF
);
    logic              start;
    logic [ADDR_W-1:0] src_addr;
    logic [ADDR_W-1:0] des_addr;
    logic [RLEN_W-1:0] compression_length;
    logic [WLEN_W-1:0] decompression_length;
    logic              rd_req;
    logic              rd_req_ack;
    logic [7:0]        rd_len;
    logic [ADDR_W-1:0] rd_address;
    logic              wr_req;
    logic              wr_req_ack;
    logic [7:0]        wr_len;
    logic [ADDR_W-1:0] wr_address;
    logic              bvalid;
    logic [1:0]        bresp;
    logic              bready;
    logic              done_i;
    logic              idle;
    logic              ready;
    logic              done_out;
    logic              error;

    modport slave (
        input  start, src_addr, des_addr, compression_length, decompression_length,
        input  rd_req_ack, wr_req_ack, bvalid, bresp, done_i,
        output rd_req, rd_len, rd_address, wr_req, wr_len, wr_address,
        output bready, idle, ready, done_out, error
    );

    modport master (
        output start, src_addr, des_addr, compression_length, decompression_length,
        output rd_req_ack, wr_req_ack, bvalid, bresp, done_i,
        input  rd_req, rd_len, rd_address, wr_req, wr_len, wr_address,
        input  bready, idle, ready, done_out, error
    );

endinterface

// File: rtl/io_burst_ctrl_burst_gen.sv
// One channel's burst splitter: captures a base/length on start, then issues
// bursts that never exceed MAX_BEATS nor cross a BOUNDARY-aligned address.
module burst_gen
    import io_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int LEN_W      = WLEN_W_DEF,
    parameter int BEAT_BYTES = BEAT_BYTES_DEF,
    parameter int MAX_BEATS  = MAX_BEATS_DEF,
    parameter int BOUNDARY   = BOUNDARY_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [LEN_W-1:0]  i_len,
    input  logic              i_hold,
    input  logic              i_ack,
    output logic              o_req,
    output logic [7:0]        o_len,
    output logic [ADDR_W-1:0] o_address,
    output logic              o_done
);
    localparam int OFF_W = $clog2(BEAT_BYTES);
    localparam int BND_W = $clog2(BOUNDARY);
    // Two spare bits absorb the in-beat offset and the ceil round-up.
    localparam int CNT_W = LEN_W + 2;
    localparam logic [BND_W:0]  BND_BYTES = (BND_W+1)'(BOUNDARY);
    localparam logic [CNT_W-1:0] MAX_B    = CNT_W'(MAX_BEATS);
    localparam logic [ADDR_W-1:0] BEAT_MASK = ADDR_W'(BEAT_BYTES - 1);

    ch_state_e r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_base;
    logic [LEN_W-1:0]  r_len_bytes;
    logic [ADDR_W-1:0] r_addr;
    logic [CNT_W-1:0]  r_beats;
    logic [CNT_W-1:0]  w_sum, w_total, w_to_bnd, w_burst;
    logic [BND_W:0]    w_bnd_bytes;
    logic              w_fire, w_capture;

    assign w_capture = (r_state == CH_IDLE || r_state == CH_DONE) && i_start;

    always_comb begin
        w_sum       = CNT_W'(r_len_bytes) + CNT_W'(r_base & BEAT_MASK) + CNT_W'(BEAT_BYTES - 1);
        w_total     = w_sum >> OFF_W;
        w_bnd_bytes = BND_BYTES - {1'b0, r_addr[BND_W-1:0]};
        w_to_bnd    = CNT_W'(w_bnd_bytes >> OFF_W);
        w_burst     = r_beats;
        if (w_burst > MAX_B)    w_burst = MAX_B;
        if (w_burst > w_to_bnd) w_burst = w_to_bnd;
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= CH_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        o_req       = 1'b0;
        case (r_state)
            CH_IDLE, CH_DONE: if (i_start) w_state_nxt = CH_CALC;
            CH_CALC:          w_state_nxt = (r_len_bytes == '0) ? CH_DONE : CH_REQ;
            CH_REQ: begin
                o_req = !i_hold;
                if (!i_hold && i_ack && r_beats == w_burst) w_state_nxt = CH_DONE;
            end
            default:          w_state_nxt = CH_IDLE;
        endcase
    end

    assign w_fire = o_req && i_ack;

    always_ff @(posedge clk) begin
        if (w_capture) begin
            r_base      <= i_addr;
            r_len_bytes <= i_len;
        end
        if (r_state == CH_CALC) begin
            r_addr  <= r_base & ~BEAT_MASK;
            r_beats <= w_total;
        end else if (w_fire) begin
            r_addr  <= r_addr + (ADDR_W'(w_burst) << OFF_W);
            r_beats <= r_beats - w_burst;
        end
    end

    assign o_len     = 8'(w_burst - CNT_W'(1));
    assign o_address = r_addr;
    assign o_done    = (r_state == CH_DONE);

endmodule

// File: rtl/io_burst_ctrl.sv
// Job-level controller: launches independent read and write burst generators,
// limits outstanding write bursts, and tracks completion and write errors.
module io_burst_ctrl
    import io_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int RLEN_W     = RLEN_W_DEF,
    parameter int WLEN_W     = WLEN_W_DEF,
    parameter int BEAT_BYTES = BEAT_BYTES_DEF,
    parameter int MAX_BEATS  = MAX_BEATS_DEF,
    parameter int BOUNDARY   = BOUNDARY_DEF,
    parameter int MAX_OUTST  = MAX_OUTST_DEF
) (
    input  logic           clk,
    input  logic           rst,
    io_burst_ctrl_if.slave bus
);
    localparam int OUT_W = $clog2(MAX_OUTST + 1);

    top_state_e r_state, w_state_nxt;
    logic              r_ready, r_error;
    logic [OUT_W-1:0]  r_outst;
    logic              w_start, w_rd_done, w_wr_done, w_hold;
    logic              w_wr_fire, w_resp, w_bready;
    logic              w_rd_req, w_wr_req;
    logic [7:0]        w_rd_len, w_wr_len;
    logic [ADDR_W-1:0] w_rd_addr, w_wr_addr;

    assign w_start   = bus.start && (r_state == TOP_IDLE);
    assign w_hold    = (r_outst == OUT_W'(MAX_OUTST));
    assign w_bready  = (r_state != TOP_IDLE);
    assign w_wr_fire = w_wr_req && bus.wr_req_ack;
    assign w_resp    = bus.bvalid && w_bready;

    burst_gen #(
        .ADDR_W(ADDR_W), .LEN_W(RLEN_W), .BEAT_BYTES(BEAT_BYTES),
        .MAX_BEATS(MAX_BEATS), .BOUNDARY(BOUNDARY)
    ) u_rd (
        .clk(clk), .rst(rst), .i_start(w_start),
        .i_addr(bus.src_addr), .i_len(bus.compression_length),
        .i_hold(1'b0), .i_ack(bus.rd_req_ack),
        .o_req(w_rd_req), .o_len(w_rd_len), .o_address(w_rd_addr), .o_done(w_rd_done)
    );

    burst_gen #(
        .ADDR_W(ADDR_W), .LEN_W(WLEN_W), .BEAT_BYTES(BEAT_BYTES),
        .MAX_BEATS(MAX_BEATS), .BOUNDARY(BOUNDARY)
    ) u_wr (
        .clk(clk), .rst(rst), .i_start(w_start),
        .i_addr(bus.des_addr), .i_len(bus.decompression_length),
        .i_hold(w_hold), .i_ack(bus.wr_req_ack),
        .o_req(w_wr_req), .o_len(w_wr_len), .o_address(w_wr_addr), .o_done(w_wr_done)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= TOP_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            TOP_IDLE:     if (w_start) w_state_nxt = TOP_BUSY;
            TOP_BUSY:     if (w_rd_done && w_wr_done) w_state_nxt = TOP_DRAIN;
            TOP_DRAIN:    if (r_outst == '0) w_state_nxt = TOP_COMPLETE;
            TOP_COMPLETE: if (bus.done_i) w_state_nxt = TOP_IDLE;
            default:      w_state_nxt = TOP_IDLE;
        endcase
    end

    // An ack and a response in the same cycle cancel out.
    always_ff @(posedge clk) begin
        if (rst)                                          r_outst <= '0;
        else if (w_wr_fire && !w_resp)                    r_outst <= r_outst + OUT_W'(1);
        else if (w_resp && !w_wr_fire && r_outst != '0)   r_outst <= r_outst - OUT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst)                                      r_error <= 1'b0;
        else if (w_start)                             r_error <= 1'b0;
        else if (w_resp && bus.bresp != BRESP_OKAY)   r_error <= 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) r_ready <= 1'b0;
        else     r_ready <= 1'b1;
    end

    assign bus.rd_req     = w_rd_req;
    assign bus.rd_len     = w_rd_len;
    assign bus.rd_address = w_rd_addr;
    assign bus.wr_req     = w_wr_req;
    assign bus.wr_len     = w_wr_len;
    assign bus.wr_address = w_wr_addr;
    assign bus.bready     = w_bready;
    assign bus.idle       = (r_state == TOP_IDLE);
    assign bus.ready      = r_ready;
    assign bus.done_out   = (r_state == TOP_COMPLETE);
    assign bus.error      = r_error;

endmodule

// File: tb/tb_io_burst_ctrl.sv
// Directed bench for io_burst_ctrl: burst splitting, boundary crossing,
// outstanding-write limit, error stickiness, completion handshake and reset.
module tb_io_burst_ctrl;
    import io_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_mis = 0;

    io_burst_ctrl_if bus ();
    io_burst_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_start(input logic [63:0] src, input logic [63:0] des,
                            input logic [34:0] rl, input logic [31:0] wl);
        bus.src_addr             = src;
        bus.des_addr             = des;
        bus.compression_length   = rl;
        bus.decompression_length = wl;
        bus.start                = 1'b1;
        tick();
        bus.start                = 1'b0;
    endtask

    task automatic rd_burst(input string tag, input logic [7:0] len, input logic [63:0] addr);
        int n = 0;
        while (bus.rd_req !== 1'b1 && n < 100) begin tick(); n++; end
        chk({tag, " rd_req"}, 64'(bus.rd_req), 64'd1);
        chk({tag, " rd_len"}, 64'(bus.rd_len), 64'(len));
        chk({tag, " rd_address"}, bus.rd_address, addr);
        bus.rd_req_ack = 1'b1;
        tick();
        bus.rd_req_ack = 1'b0;
    endtask

    task automatic wr_burst(input string tag, input logic [7:0] len, input logic [63:0] addr);
        int n = 0;
        while (bus.wr_req !== 1'b1 && n < 100) begin tick(); n++; end
        chk({tag, " wr_req"}, 64'(bus.wr_req), 64'd1);
        chk({tag, " wr_len"}, 64'(bus.wr_len), 64'(len));
        chk({tag, " wr_address"}, bus.wr_address, addr);
        bus.wr_req_ack = 1'b1;
        tick();
        bus.wr_req_ack = 1'b0;
    endtask

    task automatic resp(input logic [1:0] code);
        bus.bvalid = 1'b1;
        bus.bresp  = code;
        tick();
        bus.bvalid = 1'b0;
        bus.bresp  = BRESP_OKAY;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (bus.done_out !== 1'b1 && n < 50) begin tick(); n++; end
        chk({tag, " done_out"}, 64'(bus.done_out), 64'd1);
    endtask

    task automatic finish_job(input string tag);
        bus.done_i = 1'b1;
        tick();
        bus.done_i = 1'b0;
        chk({tag, " idle after done_i"}, 64'(bus.idle), 64'd1);
        chk({tag, " done_out after done_i"}, 64'(bus.done_out), 64'd0);
    endtask

    initial begin
        int acks;
        bus.start = 1'b0;  bus.src_addr = '0;  bus.des_addr = '0;
        bus.compression_length = '0;  bus.decompression_length = '0;
        bus.rd_req_ack = 1'b0;  bus.wr_req_ack = 1'b0;
        bus.bvalid = 1'b0;  bus.bresp = BRESP_OKAY;  bus.done_i = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        chk("rst rd_req",   64'(bus.rd_req),   64'd0);
        chk("rst wr_req",   64'(bus.wr_req),   64'd0);
        chk("rst bready",   64'(bus.bready),   64'd0);
        chk("rst done_out", 64'(bus.done_out), 64'd0);
        chk("rst error",    64'(bus.error),    64'd0);
        chk("rst idle",     64'(bus.idle),     64'd1);
        chk("rst ready",    64'(bus.ready),    64'd0);
        rst = 1'b0;
        tick();
        chk("ready after rst", 64'(bus.ready), 64'd1);

        // A: 10000 read bytes from 0x1000 -> 64+64+29 beats
        do_start(64'h1000, 64'h0, 35'd10000, 32'd0);
        chk("A idle busy", 64'(bus.idle), 64'd0);
        chk("A rd_req compute cycle", 64'(bus.rd_req), 64'd0);
        tick();
        chk("A rd_req 2 cycles", 64'(bus.rd_req), 64'd1);
        tick();
        chk("A hold rd_req", 64'(bus.rd_req), 64'd1);
        chk("A hold rd_address", bus.rd_address, 64'h1000);
        bus.start = 1'b1;
        bus.src_addr = 64'h9000;
        bus.compression_length = 35'd64;
        rd_burst("A b0", 8'd63, 64'h1000);
        bus.start = 1'b0;
        rd_burst("A b1", 8'd63, 64'h2000);
        rd_burst("A b2", 8'd28, 64'h3000);
        chk("A rd_req end", 64'(bus.rd_req), 64'd0);
        chk("A wr_req never", 64'(bus.wr_req), 64'd0);
        wait_done("A");
        finish_job("A");

        // B: boundary split on write, bad second response
        do_start(64'h0, 64'h0FC0, 35'd0, 32'd200);
        wr_burst("B b0", 8'd0, 64'h0FC0);
        wr_burst("B b1", 8'd2, 64'h1000);
        chk("B wr_req end", 64'(bus.wr_req), 64'd0);
        tick();
        tick();
        chk("B drain done_out", 64'(bus.done_out), 64'd0);
        chk("B bready", 64'(bus.bready), 64'd1);
        resp(2'b00);
        chk("B error after okay", 64'(bus.error), 64'd0);
        resp(2'b10);
        chk("B error after slverr", 64'(bus.error), 64'd1);
        wait_done("B");
        chk("B error at done", 64'(bus.error), 64'd1);
        finish_job("B");
        chk("B error held idle", 64'(bus.error), 64'd1);

        // C: zero read length, one write beat
        do_start(64'h0, 64'h2000, 35'd0, 32'd64);
        chk("C error cleared", 64'(bus.error), 64'd0);
        wr_burst("C b0", 8'd0, 64'h2000);
        chk("C rd_req none", 64'(bus.rd_req), 64'd0);
        chk("C wr_req end", 64'(bus.wr_req), 64'd0);
        chk("C done_out before resp", 64'(bus.done_out), 64'd0);
        resp(2'b00);
        wait_done("C");
        finish_job("C");

        // D: 20 bursts of 64 beats against the outstanding limit
        do_start(64'h0, 64'h0, 35'd0, 32'd81920);
        bus.wr_req_ack = 1'b1;
        acks = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.wr_req === 1'b1) acks++;
            tick();
        end
        chk("D acks at limit", 64'(acks), 64'd16);
        chk("D wr_req held low", 64'(bus.wr_req), 64'd0);
        bus.bvalid = 1'b1;
        tick();
        bus.bvalid = 1'b0;
        chk("D wr_req reopens", 64'(bus.wr_req), 64'd1);
        bus.bvalid = 1'b1;
        tick();
        bus.bvalid = 1'b0;
        chk("D ack+resp keeps count", 64'(bus.wr_req), 64'd1);
        tick();
        chk("D wr_req relimited", 64'(bus.wr_req), 64'd0);
        bus.wr_req_ack = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("D rst wr_req", 64'(bus.wr_req), 64'd0);
        chk("D rst idle", 64'(bus.idle), 64'd1);
        chk("D rst bready", 64'(bus.bready), 64'd0);
        tick();

        // E: reset mid-read, then an unaligned clean job
        do_start(64'h1000, 64'h0, 35'd10000, 32'd0);
        tick();
        chk("E rd_req before rst", 64'(bus.rd_req), 64'd1);
        rst = 1'b1;
        tick();
        chk("E rst rd_req", 64'(bus.rd_req), 64'd0);
        chk("E rst idle", 64'(bus.idle), 64'd1);
        chk("E rst ready", 64'(bus.ready), 64'd0);
        chk("E rst done_out", 64'(bus.done_out), 64'd0);
        rst = 1'b0;
        tick();
        chk("E ready again", 64'(bus.ready), 64'd1);
        chk("E rd_req stays low", 64'(bus.rd_req), 64'd0);
        do_start(64'h1030, 64'h0, 35'd64, 32'd0);
        rd_burst("E b0", 8'd1, 64'h1000);
        chk("E rd_req end", 64'(bus.rd_req), 64'd0);
        wait_done("E");
        finish_job("E");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
